sys_ram: RTL and testbench
==========================

# sys_ram

Behavioural main-memory block that sits directly downstream of the multicore top level. It consumes the single RAM request stream that the coherence/memory controller drives out: word address, store data, read enable and write enable. It answers with load data and a four-valued RAM state after a programmable access latency. It is the synthesizable RAM stage used under the dual-core system in simulation and on the FPGA build.

## Interface
Parameters:
- ADDR_BITS, 10: number of word-index bits; array depth is 2^ADDR_BITS 32-bit words.
- LAT, 2: wait cycles before an access completes; legal range 0..15.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- nRST  input  1  reset, synchronous, active-low; sampled on the rising CLK edge.
- memaddr  input  32  byte address; bits [1:0] ignored; word index = memaddr[ADDR_BITS+1:2].
- memstore  input  32  write data.
- memREN  input  1  read request; held by the requester until ACCESS is seen.
- memWEN  input  1  write request; held by the requester until ACCESS is seen.
- ramload  output  32  read data.
- ramstate  output  2  FREE=2'b00, BUSY=2'b01, ACCESS=2'b10, ERROR=2'b11.

## Operation
- Request active: req = memREN ^ memWEN.
- Illegal request: memREN & memWEN, or any set bit in memaddr[31:ADDR_BITS+2] while REN or WEN is high. Gives ramstate = ERROR combinationally. No write, counter held at 0.
- Registers:
  - 4-bit wait counter cnt.
  - Last-request tag: word index, op bit and valid bit.
- Each cycle, classify the request:
  - same = req & tag valid & index and op equal to the tag.
  - Not same: the request is new; its effective count is 0 this cycle.
- ramstate (combinational):
  - ERROR if illegal.
  - Else FREE if !req.
  - Else ACCESS if the effective count == LAT.
  - Else BUSY.
- ramload:
  - mem[index] during a read ACCESS. Combinational read of the current array contents; a write committed at the previous edge is visible.
  - 32'hBAD1BAD1 in every other cycle.
- Write commit: mem[index] <= memstore on the edge that ends a write ACCESS cycle. Exactly one array write per completed write access.
- Counter and tag update at each edge:
  - ACCESS: cnt <= 0 and tag valid <= 0. A request still held after ACCESS counts as a fresh access with the full latency again.
  - BUSY: cnt <= effective count + 1; tag <= current index/op; valid <= 1.
  - FREE or ERROR: cnt <= 0; valid <= 0.
- A change of address or op during BUSY abandons the old access and restarts the count for the new one. Nothing is written for the abandoned access.
- memstore may change during BUSY. The value present in the ACCESS cycle is the one written.
- Array contents are not reset. The testbench initialises memory by writing through the port.

## Timing
- Reset (nRST low at an edge): cnt = 0 and tag valid = 0. Outputs are combinational from these and the inputs, so with REN = WEN = 0 during reset, ramstate = FREE and ramload = 32'hBAD1BAD1.
- Reset asserted mid-access: the access is abandoned with no array write. After release, a still-held request starts from count 0.
- Latency: a request first presented in cycle t (legal, stable) is BUSY in cycles t..t+LAT-1 and ACCESS in cycle t+LAT.
- LAT = 0: ACCESS in the same cycle the request appears. A held request then gets ACCESS every cycle; a held write therefore writes every cycle.
- Back-to-back accesses: the requester may present a new address in the cycle after ACCESS. The minimum spacing between completions is LAT+1 cycles.
- An ERROR cycle does not advance the count. Once the request becomes legal, it starts from count 0.

## Test plan
- Reset: hold nRST=0 for 2 cycles with REN=WEN=0 -> ramstate=FREE, ramload=32'hBAD1BAD1; release -> still FREE.
- Write/read, LAT=2:
  - Write memaddr=0x40, memstore=0xDEADBEEF held -> BUSY, BUSY, ACCESS; drop WEN.
  - Read 0x40 -> BUSY, BUSY, then ACCESS with ramload=0xDEADBEEF.
- LAT=0 instance: write 0x8 = 0x12345678 -> ACCESS in the first cycle. Read 0x8 in the next cycle -> ACCESS immediately with ramload=0x12345678.
- Restart: LAT=3, read 0x100. Switch to 0x104 after 2 BUSY cycles -> 3 further BUSY cycles, then ACCESS with mem[0x104]. Verify mem[0x100] is unchanged.
- Errors:
  - REN=WEN=1 at 0x10 -> ERROR every cycle, no write.
  - ADDR_BITS=10 and memaddr=0x1000 -> ERROR.
  - Then a legal read -> full LAT of BUSY before ACCESS.
- Reset mid-write: write 0x20 = 0xAAAA5555 (prior value 0x0). Pulse nRST low during the second BUSY cycle -> no write; a subsequent read of 0x20 returns 0x0.

Source files
------------

// File: rtl/sys_ram.sv
// Behavioural main memory behind the coherence controller: one request stream,
// fixed-latency completion reported through a four-valued ramstate.
module sys_ram #(
    parameter int ADDR_BITS = 10,
    parameter int LAT       = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] memaddr,
    input  logic [31:0] memstore,
    input  logic        memREN,
    input  logic        memWEN,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);

    localparam logic [1:0]  FREE     = 2'b00;
    localparam logic [1:0]  BUSY     = 2'b01;
    localparam logic [1:0]  ACCESS   = 2'b10;
    localparam logic [1:0]  ERROR    = 2'b11;
    localparam logic [3:0]  LAT_CNT  = 4'(LAT);
    localparam logic [31:0] IDLE_VAL = 32'hBAD1BAD1;
    localparam int unsigned DEPTH    = 2 ** ADDR_BITS;

    logic [ADDR_BITS-1:0] idx;
    logic                 addr_hi;
    logic                 unused_lsb;

    logic                 req;
    logic                 illegal;
    logic                 same;
    logic [3:0]           eff_cnt;
    logic [1:0]           state;
    logic                 mem_we;

    logic [3:0]           cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] tag_idx_q, tag_idx_d;
    logic                 tag_op_q, tag_op_d;
    logic                 tag_vld_q, tag_vld_d;

    logic [31:0]          mem_q [DEPTH];

    assign idx        = memaddr[ADDR_BITS+1:2];
    assign addr_hi    = |memaddr[31:ADDR_BITS+2];
    assign unused_lsb = ^memaddr[1:0];

    always_comb begin
        req     = memREN ^ memWEN;
        illegal = (memREN & memWEN) | ((memREN | memWEN) & addr_hi);
        // Only a request matching the last BUSY tag keeps its count; anything else starts over.
        same    = req & tag_vld_q & (tag_idx_q == idx) & (tag_op_q == memWEN);
        eff_cnt = same ? cnt_q : '0;

        if (illegal) begin
            state = ERROR;
        end else if (!req) begin
            state = FREE;
        end else if (eff_cnt == LAT_CNT) begin
            state = ACCESS;
        end else begin
            state = BUSY;
        end

        ramstate = state;
        ramload  = (state == ACCESS && memREN) ? mem_q[idx] : IDLE_VAL;
        mem_we   = nRST & (state == ACCESS) & memWEN;

        cnt_d     = '0;
        tag_vld_d = 1'b0;
        tag_idx_d = tag_idx_q;
        tag_op_d  = tag_op_q;
        if (state == BUSY) begin
            cnt_d     = eff_cnt + 4'd1;
            tag_idx_d = idx;
            tag_op_d  = memWEN;
            tag_vld_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt_q     <= '0;
            tag_idx_q <= '0;
            tag_op_q  <= 1'b0;
            tag_vld_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tag_idx_q <= tag_idx_d;
            tag_op_q  <= tag_op_d;
            tag_vld_q <= tag_vld_d;
        end
    end

    // Array contents are deliberately left unreset.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[idx] <= memstore;
        end
    end

endmodule

// File: tb/tb_sys_ram.sv
// Bench for sys_ram: directed literal scenarios on three latency variants, then
// random traffic checked every cycle against a timestamp-based reference model.
module tb_sys_ram;

    localparam logic [1:0]  FREE   = 2'b00;
    localparam logic [1:0]  BUSY   = 2'b01;
    localparam logic [1:0]  ACCESS = 2'b10;
    localparam logic [1:0]  ERROR  = 2'b11;
    localparam logic [31:0] BAD    = 32'hBAD1BAD1;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        ren   [3];
    logic        wen   [3];
    logic [31:0] addr  [3];
    logic [31:0] store [3];
    logic [31:0] load  [3];
    logic [1:0]  st    [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // u0: LAT=2, u1: LAT=0, u2: LAT=3
    sys_ram #(.ADDR_BITS(10), .LAT(2)) u_lat2 (
        .CLK(clk), .nRST(nrst), .memaddr(addr[0]), .memstore(store[0]),
        .memREN(ren[0]), .memWEN(wen[0]), .ramload(load[0]), .ramstate(st[0]));
    sys_ram #(.ADDR_BITS(10), .LAT(0)) u_lat0 (
        .CLK(clk), .nRST(nrst), .memaddr(addr[1]), .memstore(store[1]),
        .memREN(ren[1]), .memWEN(wen[1]), .ramload(load[1]), .ramstate(st[1]));
    sys_ram #(.ADDR_BITS(10), .LAT(3)) u_lat3 (
        .CLK(clk), .nRST(nrst), .memaddr(addr[2]), .memstore(store[2]),
        .memREN(ren[2]), .memWEN(wen[2]), .ramload(load[2]), .ramstate(st[2]));

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference model: an access started in cycle t completes in cycle t+LAT.
    logic [31:0] mmem   [3][1024];
    bit          mknown [3][1024];
    bit          trk_act   [3];
    int unsigned trk_idx   [3];
    bit          trk_op    [3];
    int unsigned trk_start [3];
    int unsigned cyc = 0;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int unsigned ix;
            int unsigned age;
            bit          bad;
            bit          rq;
            bit          match;
            logic [1:0]  es;
            ix    = 32'(addr[k][11:2]);
            bad   = (ren[k] && wen[k]) || ((ren[k] || wen[k]) && (addr[k][31:12] != 20'h0));
            rq    = ren[k] ^ wen[k];
            match = trk_act[k] && trk_idx[k] == ix && trk_op[k] == wen[k];
            age   = match ? cyc - trk_start[k] : 0;
            if (bad)                     es = ERROR;
            else if (!rq)                es = FREE;
            else if (age == lat_of(k))   es = ACCESS;
            else                         es = BUSY;

            chk($sformatf("model u%0d state", k), 32'(st[k]), 32'(es));
            if (es == ACCESS && ren[k]) begin
                if (mknown[k][ix]) chk($sformatf("model u%0d load", k), load[k], mmem[k][ix]);
            end else begin
                chk($sformatf("model u%0d idle load", k), load[k], BAD);
            end

            if (!nrst) begin
                trk_act[k] = 1'b0;
            end else if (es == ACCESS) begin
                trk_act[k] = 1'b0;
                if (wen[k]) begin
                    mmem[k][ix]   = store[k];
                    mknown[k][ix] = 1'b1;
                end
            end else if (es == BUSY) begin
                if (!match) trk_start[k] = cyc;
                trk_act[k] = 1'b1;
                trk_idx[k] = ix;
                trk_op[k]  = wen[k];
            end else begin
                trk_act[k] = 1'b0;
            end
        end
        cyc++;
    end

    task automatic step(input int k, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] es, input logic [31:0] el,
                        input string nm);
        @(posedge clk);
        #1;
        ren[k] = r; wen[k] = w; addr[k] = a; store[k] = d;
        #1;
        chk({nm, " state"}, 32'(st[k]), 32'(es));
        chk({nm, " load"}, load[k], el);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            ren[k] = 1'b0; wen[k] = 1'b0; addr[k] = '0; store[k] = '0;
        end

        step(0, 0, 0, 32'h0, 32'h0, FREE, BAD, "reset c1");
        step(0, 0, 0, 32'h0, 32'h0, FREE, BAD, "reset c2");
        nrst = 1'b1;
        step(0, 0, 0, 32'h0, 32'h0, FREE, BAD, "after reset");

        step(0, 0, 1, 32'h40, 32'hDEADBEEF, BUSY,   BAD, "wr40 c0");
        step(0, 0, 1, 32'h40, 32'hDEADBEEF, BUSY,   BAD, "wr40 c1");
        step(0, 0, 1, 32'h40, 32'hDEADBEEF, ACCESS, BAD, "wr40 c2");
        step(0, 0, 0, 32'h40, 32'h0,        FREE,   BAD, "wr40 drop");
        step(0, 1, 0, 32'h40, 32'h0, BUSY,   BAD,          "rd40 c0");
        step(0, 1, 0, 32'h40, 32'h0, BUSY,   BAD,          "rd40 c1");
        step(0, 1, 0, 32'h40, 32'h0, ACCESS, 32'hDEADBEEF, "rd40 c2");
        step(0, 0, 0, 32'h0,  32'h0, FREE,   BAD,          "rd40 drop");

        step(1, 0, 1, 32'h8, 32'h12345678, ACCESS, BAD,          "lat0 wr8");
        step(1, 1, 0, 32'h8, 32'h0,        ACCESS, 32'h12345678, "lat0 rd8");
        step(1, 0, 0, 32'h0, 32'h0,        FREE,   BAD,          "lat0 drop");

        for (int c = 0; c < 3; c++) step(2, 0, 1, 32'h104, 32'hCAFE0104, BUSY, BAD, "lat3 wr104 busy");
        step(2, 0, 1, 32'h104, 32'hCAFE0104, ACCESS, BAD, "lat3 wr104 acc");
        for (int c = 0; c < 3; c++) step(2, 0, 1, 32'h100, 32'h01000100, BUSY, BAD, "lat3 wr100 busy");
        step(2, 0, 1, 32'h100, 32'h01000100, ACCESS, BAD, "lat3 wr100 acc");
        step(2, 1, 0, 32'h100, 32'h0, BUSY, BAD, "restart rd100 c0");
        step(2, 1, 0, 32'h100, 32'h0, BUSY, BAD, "restart rd100 c1");
        for (int c = 0; c < 3; c++) step(2, 1, 0, 32'h104, 32'h0, BUSY, BAD, "restart rd104 busy");
        step(2, 1, 0, 32'h104, 32'h0, ACCESS, 32'hCAFE0104, "restart rd104 acc");
        step(2, 0, 0, 32'h0,   32'h0, FREE,   BAD,          "restart drop");
        for (int c = 0; c < 3; c++) step(2, 1, 0, 32'h100, 32'h0, BUSY, BAD, "rd100 busy");
        step(2, 1, 0, 32'h100, 32'h0, ACCESS, 32'h01000100, "rd100 unchanged");
        step(2, 0, 0, 32'h0,   32'h0, FREE,   BAD,          "rd100 drop");

        step(0, 0, 1, 32'h10, 32'h11110000, BUSY,   BAD, "wr10 c0");
        step(0, 0, 1, 32'h10, 32'h11110000, BUSY,   BAD, "wr10 c1");
        step(0, 0, 1, 32'h10, 32'h11110000, ACCESS, BAD, "wr10 c2");
        step(0, 1, 1, 32'h10,   32'hFFFFFFFF, ERROR, BAD, "err both c0");
        step(0, 1, 1, 32'h10,   32'hFFFFFFFF, ERROR, BAD, "err both c1");
        step(0, 1, 0, 32'h1000, 32'h0,        ERROR, BAD, "err range c0");
        step(0, 1, 0, 32'h1000, 32'h0,        ERROR, BAD, "err range c1");
        step(0, 1, 0, 32'h10, 32'h0, BUSY,   BAD,          "post-err rd c0");
        step(0, 1, 0, 32'h10, 32'h0, BUSY,   BAD,          "post-err rd c1");
        step(0, 1, 0, 32'h10, 32'h0, ACCESS, 32'h11110000, "post-err rd c2");

        step(0, 0, 1, 32'h20, 32'h0, BUSY,   BAD, "wr20 zero c0");
        step(0, 0, 1, 32'h20, 32'h0, BUSY,   BAD, "wr20 zero c1");
        step(0, 0, 1, 32'h20, 32'h0, ACCESS, BAD, "wr20 zero c2");
        step(0, 0, 0, 32'h0,  32'h0, FREE,   BAD, "wr20 zero drop");
        step(0, 0, 1, 32'h20, 32'hAAAA5555, BUSY, BAD, "rst-mid wr c0");
        step(0, 0, 1, 32'h20, 32'hAAAA5555, BUSY, BAD, "rst-mid wr c1");
        nrst = 1'b0;
        step(0, 0, 0, 32'h0, 32'h0, FREE, BAD, "rst-mid drop");
        nrst = 1'b1;
        step(0, 1, 0, 32'h20, 32'h0, BUSY,   BAD,   "rst-mid rd c0");
        step(0, 1, 0, 32'h20, 32'h0, BUSY,   BAD,   "rst-mid rd c1");
        step(0, 1, 0, 32'h20, 32'h0, ACCESS, 32'h0, "rst-mid rd c2");
        step(0, 0, 0, 32'h0,  32'h0, FREE,   BAD,   "rst-mid rd drop");

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            nrst = ($urandom_range(0, 99) != 0);
            for (int k = 0; k < 3; k++) begin
                int unsigned sel;
                logic [31:0] a;
                if ($urandom_range(0, 5) == 0) begin
                    sel = $urandom_range(0, 9);
                    a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
                    if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(12, 31));
                    ren[k]  = (sel < 4) || (sel == 9);
                    wen[k]  = (sel >= 4 && sel < 8) || (sel == 9);
                    addr[k] = a;
                end
                if ($urandom_range(0, 3) == 0) store[k] = $urandom();
            end
        end

        @(posedge clk);
        #1;
        nrst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ren[k] = 1'b0; wen[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
